// File: rtl/mips_memsys_if.sv
// Memory-bus and loader bundle between the MIPS core side and mips_memsys.
// slave is the memory responder's view, master is the core/loader view.
interface mips_memsys_if #(
  parameter int WIDTH = 8
) ();
  logic             load_valid;
  logic [7:0]       load_data;
  logic             load_last;
  logic             load_ready;
  logic             cpu_reset;
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;
  logic [7:0]       io_out;
  logic             io_strobe;

  modport slave (
    input  load_valid, load_data, load_last,
    input  memread, memwrite, adr, writedata,
    output load_ready, cpu_reset, memdata, io_out, io_strobe
  );

  modport master (
    output load_valid, load_data, load_last,
    output memread, memwrite, adr, writedata,
    input  load_ready, cpu_reset, memdata, io_out, io_strobe
  );
endinterface

// File: rtl/mips_memsys.sv
// Byte-wide memory responder and boot loader for the 8-bit multicycle MIPS.
// Streams a program image into RAM while holding the core in reset, then
// serves fetches, loads and stores; the top address is an output port.
module mips_memsys #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] IOADR = {WIDTH{1'b1}}
) (
  input  logic          clk,
  input  logic          reset,
  mips_memsys_if.slave  bus
);

  localparam int               DEPTH   = int'(IOADR);
  localparam logic [WIDTH-1:0] LASTADR = IOADR - WIDTH'(1);

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ldCnt_q, ldCnt_d;
  logic [7:0]       ioOut_q, ioOut_d;
  logic             ioStrobe_q, ioStrobe_d;

  logic             ramWe;
  logic [WIDTH-1:0] ramAddr;
  logic [WIDTH-1:0] ramWdata;

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Next state, loader counter, output-port update and the single RAM write port.
  always_comb begin
    state_d    = state_q;
    ldCnt_d    = ldCnt_q;
    ioOut_d    = ioOut_q;
    ioStrobe_d = 1'b0;
    ramWe      = 1'b0;
    ramAddr    = ldCnt_q;
    ramWdata   = WIDTH'(bus.load_data);
    unique case (state_q)
      LOAD: begin
        if (bus.load_valid) begin
          ramWe   = 1'b1;
          ldCnt_d = ldCnt_q + WIDTH'(1);
          if (bus.load_last || (ldCnt_q == LASTADR)) begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        state_d = RUN;
      end
      RUN: begin
        if (bus.memwrite) begin
          if (bus.adr == IOADR) begin
            ioOut_d    = bus.writedata[7:0];
            ioStrobe_d = 1'b1;
          end else begin
            ramWe    = 1'b1;
            ramAddr  = bus.adr;
            ramWdata = bus.writedata;
          end
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // State, loader counter and output-port registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= LOAD;
      ldCnt_q    <= '0;
      ioOut_q    <= '0;
      ioStrobe_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ldCnt_q    <= ldCnt_d;
      ioOut_q    <= ioOut_d;
      ioStrobe_q <= ioStrobe_d;
    end
  end

  // RAM write; contents survive reset, but a write in a reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (ramWe && !reset) begin
      mem_q[ramAddr] <= ramWdata;
    end
  end

  // Same-cycle read data: the core latches it at the edge ending its read cycle.
  always_comb begin
    bus.memdata = '0;
    if ((state_q == RUN) && bus.memread) begin
      if (bus.adr == IOADR) begin
        bus.memdata = WIDTH'(ioOut_q);
      end else begin
        bus.memdata = mem_q[bus.adr];
      end
    end
  end

  assign bus.load_ready = (state_q == LOAD);
  assign bus.cpu_reset  = (state_q != RUN);
  assign bus.io_out     = ioOut_q;
  assign bus.io_strobe  = ioStrobe_q;

endmodule

// File: tb/tb_mips_memsys.sv
// Self-checking bench for mips_memsys: directed loader and core-bus vectors,
// a behavioural model checked every cycle, and hand-computed literal checks.
module tb_mips_memsys;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  mips_memsys_if #(.WIDTH(WIDTH)) bus ();

  mips_memsys #(.WIDTH(WIDTH), .IOADR(8'hFF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Behavioural model state.
  logic [7:0] mMem [256];
  bit         mKnown [256];
  bit         mLoading;
  bit         mRelease;
  int         mNext;
  logic [7:0] mIo;
  bit         mStrobe;
  bit         modelReady = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then wait to mid-cycle.
  task automatic applyStimulus(input logic rst, input logic v, input logic [7:0] d, input logic last,
                               input logic mr, input logic mw, input logic [7:0] a, input logic [7:0] wd);
    @(posedge clk);
    #1;
    reset           = rst;
    bus.load_valid  = v;
    bus.load_data   = d;
    bus.load_last   = last;
    bus.memread     = mr;
    bus.memwrite    = mw;
    bus.adr         = a;
    bus.writedata   = wd;
    @(negedge clk);
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic doReset();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic loadByte(input logic [7:0] d, input logic last);
    applyStimulus(1'b0, 1'b1, d, last, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic storeByte(input logic [7:0] a, input logic [7:0] d);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, a, d);
  endtask

  task automatic readByte(input logic [7:0] a);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, a, 8'h00);
  endtask

  // Model: loader fills bytes in order until the last marker or the byte just
  // below the port address, one cycle of held reset follows, then the core
  // bus is served with the top address acting as an output latch.
  always @(posedge clk) begin
    if (reset) begin
      mLoading   = 1'b1;
      mRelease   = 1'b0;
      mNext      = 0;
      mIo        = 8'h00;
      mStrobe    = 1'b0;
      modelReady = 1'b1;
    end else if (modelReady) begin
      mStrobe = 1'b0;
      if (mLoading) begin
        if (bus.load_valid) begin
          mMem[mNext]   = bus.load_data;
          mKnown[mNext] = 1'b1;
          if (bus.load_last || mNext == 254) begin
            mLoading = 1'b0;
            mRelease = 1'b1;
          end
          mNext = mNext + 1;
        end
      end else if (mRelease) begin
        mRelease = 1'b0;
      end else if (bus.memwrite) begin
        if (bus.adr == 8'hFF) begin
          mIo     = bus.writedata;
          mStrobe = 1'b1;
        end else begin
          mMem[bus.adr]   = bus.writedata;
          mKnown[bus.adr] = 1'b1;
        end
      end
    end
  end

  // Compare the DUT against the model in the middle of every cycle.
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("cyc_cpu_reset", 32'(bus.cpu_reset), 32'(mLoading || mRelease));
      checkOutput("cyc_load_ready", 32'(bus.load_ready), 32'(mLoading));
      checkOutput("cyc_io_out", 32'(bus.io_out), 32'(mIo));
      checkOutput("cyc_io_strobe", 32'(bus.io_strobe), 32'(mStrobe));
      if (!(mLoading || mRelease) && bus.memread) begin
        if (bus.adr == 8'hFF) begin
          checkOutput("cyc_memdata_io", 32'(bus.memdata), 32'(mIo));
        end else if (mKnown[bus.adr]) begin
          checkOutput("cyc_memdata_ram", 32'(bus.memdata), 32'(mMem[bus.adr]));
        end
      end else begin
        checkOutput("cyc_memdata_zero", 32'(bus.memdata), 32'h0);
      end
    end
  end

  initial begin
    int accepted;
    for (int i = 0; i < 256; i++) begin
      mKnown[i] = 1'b0;
      mMem[i]   = 8'h00;
    end
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.load_last  = 1'b0;
    bus.memread    = 1'b0;
    bus.memwrite   = 1'b0;
    bus.adr        = 8'h00;
    bus.writedata  = 8'h00;

    // Reset state, with a read attempted and a store to the port while in reset.
    doReset();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h77);
    checkOutput("rst_cpu_reset", 32'(bus.cpu_reset), 32'h1);
    checkOutput("rst_load_ready", 32'(bus.load_ready), 32'h1);
    checkOutput("rst_memdata", 32'(bus.memdata), 32'h0);
    checkOutput("rst_io_out", 32'(bus.io_out), 32'h0);
    checkOutput("rst_io_strobe", 32'(bus.io_strobe), 32'h0);

    // Four-byte image with load_valid held high.
    loadByte(8'h20, 1'b0);
    checkOutput("load_ready_first", 32'(bus.load_ready), 32'h1);
    loadByte(8'h01, 1'b0);
    loadByte(8'h02, 1'b0);
    loadByte(8'h80, 1'b1);
    idle();
    checkOutput("release_load_ready", 32'(bus.load_ready), 32'h0);
    checkOutput("release_cpu_reset", 32'(bus.cpu_reset), 32'h1);
    readByte(8'h00);
    checkOutput("run_cpu_reset", 32'(bus.cpu_reset), 32'h0);
    checkOutput("fetch_adr0", 32'(bus.memdata), 32'h20);
    readByte(8'h01);
    checkOutput("fetch_adr1", 32'(bus.memdata), 32'h01);
    readByte(8'h03);
    checkOutput("fetch_adr3", 32'(bus.memdata), 32'h80);
    loadByte(8'hEE, 1'b1);
    checkOutput("run_ignores_loader", 32'(bus.load_ready), 32'h0);

    // Loader with gaps; junk data on idle cycles must not land in RAM.
    doReset();
    loadByte(8'h11, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'hEE, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    loadByte(8'h22, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'hEE, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    loadByte(8'h33, 1'b1);
    idle();
    readByte(8'h00);
    checkOutput("gap_adr0", 32'(bus.memdata), 32'h11);
    readByte(8'h01);
    checkOutput("gap_adr1", 32'(bus.memdata), 32'h22);
    readByte(8'h02);
    checkOutput("gap_adr2", 32'(bus.memdata), 32'h33);
    readByte(8'h03);
    checkOutput("gap_adr3_kept", 32'(bus.memdata), 32'h80);

    // RAM store then read-after-write.
    storeByte(8'h40, 8'h5A);
    readByte(8'h40);
    checkOutput("raw_0x40", 32'(bus.memdata), 32'h5A);

    // Output-port store: strobe for one cycle, RAM untouched, readback.
    storeByte(8'hFF, 8'hA7);
    idle();
    checkOutput("io_strobe_pulse", 32'(bus.io_strobe), 32'h1);
    checkOutput("io_out_a7", 32'(bus.io_out), 32'hA7);
    readByte(8'hFF);
    checkOutput("io_strobe_end", 32'(bus.io_strobe), 32'h0);
    checkOutput("io_readback", 32'(bus.memdata), 32'hA7);
    readByte(8'h40);
    checkOutput("io_ram_untouched", 32'(bus.memdata), 32'h5A);

    // Back-to-back port stores give a strobe in each cycle.
    storeByte(8'hFF, 8'h01);
    storeByte(8'hFF, 8'h02);
    checkOutput("b2b_strobe1", 32'(bus.io_strobe), 32'h1);
    checkOutput("b2b_io1", 32'(bus.io_out), 32'h01);
    idle();
    checkOutput("b2b_strobe2", 32'(bus.io_strobe), 32'h1);
    checkOutput("b2b_io2", 32'(bus.io_out), 32'h02);
    idle();
    checkOutput("b2b_strobe_end", 32'(bus.io_strobe), 32'h0);

    // Read and write together: old data now, new data next cycle.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h40, 8'h66);
    checkOutput("rw_old_value", 32'(bus.memdata), 32'h5A);
    readByte(8'h40);
    checkOutput("rw_new_value", 32'(bus.memdata), 32'h66);

    // Reset mid-RUN while a store is presented: the store is dropped.
    storeByte(8'h20, 8'h99);
    storeByte(8'h10, 8'h44);
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h10, 8'h33);
    idle();
    checkOutput("midrst_cpu_reset", 32'(bus.cpu_reset), 32'h1);
    checkOutput("midrst_load_ready", 32'(bus.load_ready), 32'h1);
    checkOutput("midrst_io_out", 32'(bus.io_out), 32'h0);
    loadByte(8'hC3, 1'b1);
    idle();
    readByte(8'h10);
    checkOutput("midrst_dropped", 32'(bus.memdata), 32'h44);
    readByte(8'h20);
    checkOutput("midrst_ram_kept", 32'(bus.memdata), 32'h99);
    readByte(8'h00);
    checkOutput("midrst_reload", 32'(bus.memdata), 32'hC3);

    // Overflow guard: 260 bytes offered with no last marker.
    doReset();
    accepted = 0;
    for (int i = 0; i < 260; i++) begin
      loadByte(8'(i + 8'h30), 1'b0);
      if (bus.load_ready) accepted++;
    end
    checkOutput("ovf_accepted", 32'(accepted), 32'd255);
    readByte(8'hFD);
    checkOutput("ovf_adr_fd", 32'(bus.memdata), 32'h2D);
    readByte(8'hFE);
    checkOutput("ovf_adr_fe", 32'(bus.memdata), 32'h2E);
    readByte(8'h00);
    checkOutput("ovf_adr_00", 32'(bus.memdata), 32'h30);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
